exe_ctrl: RTL

Execution unit controller and the consumer of the instruction decode unit's one-hot decode bundle. It accepts one decoded instruction per valid/ready handshake and owns the 8x8-bit register file and the compare flag. It executes ALU/move/compare operations in one cycle and sequences loads and stores over a req/ack data-memory port. It reports each completed instruction on a registered writeback/retire interface.

---
 rtl/exe_pkg.sv | 36 +++
 rtl/exe_ctrl_if.sv | 52 +++++
 rtl/exe_alu.sv | 46 ++++
 rtl/exe_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execution controller slice.
//   DW_DEF/RAW_DEF/MAW_DEF : default data, register-index and memory-address widths
//   state_e                : controller FSM states
//   op_e                   : encoded opcode, bit position of each decode strobe plus OP_ILL
//   encode_op()            : one-hot strobe vector -> op_e (OP_ILL unless exactly one bit set)
package exe_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned RAW_DEF = 3;
  localparam int unsigned MAW_DEF = 8;
  localparam int unsigned NUM_OPS = 12;

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_e;

  // Enum order matches the strobe bit order used to build the strobe vector.
  typedef enum logic [3:0] {
    OP_LD, OP_AND, OP_STR, OP_ADD, OP_ADDI, OP_CMPLT, OP_CMPEQ,
    OP_CMPEQI, OP_SHFTR, OP_SHFTL, OP_INV, OP_MVI, OP_ILL
  } op_e;

  function automatic op_e encode_op(input logic [NUM_OPS-1:0] strobes);
    op_e         op;
    int unsigned hits;
    op   = OP_ILL;
    hits = 0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (strobes[i]) begin
        hits++;
        op = op_e'(4'(i));
      end
    end
    if (hits != 1) op = OP_ILL;
    return op;
  endfunction

endpackage

// File: rtl/exe_ctrl_if.sv
// Bus bundle between the execution controller and its environment.
//   decode side : id_valid_i/id_ready_o handshake, twelve one-hot strobes, imm/src/dst fields
//   memory side : mem_req_o/we/addr/wdata request, mem_ack_i/mem_rdata_i completion
//   status side : wb_valid_o/wb_reg_o/wb_data_o, cmp_flag_o, retire_o, illegal_o
// modport slave is the controller; modport master is the decoder/memory/observer side.
interface exe_ctrl_if
  import exe_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned RAW = RAW_DEF,
  parameter int unsigned MAW = MAW_DEF
) ();

  logic           id_valid_i;
  logic           id_ready_o;
  logic           id_ld_i, id_and_i, id_str_i, id_add_i, id_addi_i, id_cmplt_i;
  logic           id_cmpeq_i, id_cmpeqi_i, id_shftr_i, id_shftl_i, id_inv_i, id_mvi_i;
  logic [MAW-1:0] imm_addr_const_i;
  logic [RAW-1:0] src_reg_i;
  logic [RAW-1:0] dst_reg_i;

  logic           mem_req_o;
  logic           mem_we_o;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0]  mem_wdata_o;
  logic           mem_ack_i;
  logic [DW-1:0]  mem_rdata_i;

  logic           wb_valid_o;
  logic [RAW-1:0] wb_reg_o;
  logic [DW-1:0]  wb_data_o;
  logic           cmp_flag_o;
  logic           retire_o;
  logic           illegal_o;

  modport master (
    output id_valid_i, id_ld_i, id_and_i, id_str_i, id_add_i, id_addi_i, id_cmplt_i,
           id_cmpeq_i, id_cmpeqi_i, id_shftr_i, id_shftl_i, id_inv_i, id_mvi_i,
           imm_addr_const_i, src_reg_i, dst_reg_i, mem_ack_i, mem_rdata_i,
    input  id_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           wb_valid_o, wb_reg_o, wb_data_o, cmp_flag_o, retire_o, illegal_o
  );

  modport slave (
    input  id_valid_i, id_ld_i, id_and_i, id_str_i, id_add_i, id_addi_i, id_cmplt_i,
           id_cmpeq_i, id_cmpeqi_i, id_shftr_i, id_shftl_i, id_inv_i, id_mvi_i,
           imm_addr_const_i, src_reg_i, dst_reg_i, mem_ack_i, mem_rdata_i,
    output id_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           wb_valid_o, wb_reg_o, wb_data_o, cmp_flag_o, retire_o, illegal_o
  );

endinterface

// File: rtl/exe_alu.sv
// Single-cycle combinational ALU for the execution controller.
//   op       : encoded opcode
//   rd/rs    : destination and source register values (pre-write)
//   imm      : immediate field
//   result   : value to write into Rd when reg_we is set
//   flag_we  : compare instruction, load flag_val into the compare flag
module exe_alu
  import exe_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned MAW = MAW_DEF
) (
  input  op_e            op,
  input  logic [DW-1:0]  rd,
  input  logic [DW-1:0]  rs,
  input  logic [MAW-1:0] imm,
  output logic [DW-1:0]  result,
  output logic           reg_we,
  output logic           flag_we,
  output logic           flag_val
);

  logic [DW-1:0] imm_ext;
  assign imm_ext = DW'(imm);

  always_comb begin
    result   = '0;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    flag_val = 1'b0;
    unique case (op)
      OP_AND:    begin result = rd & rs;        reg_we = 1'b1; end
      OP_ADD:    begin result = rd + rs;        reg_we = 1'b1; end
      OP_ADDI:   begin result = rd + imm_ext;   reg_we = 1'b1; end
      OP_SHFTR:  begin result = rd >> 1;        reg_we = 1'b1; end
      OP_SHFTL:  begin result = rd << 1;        reg_we = 1'b1; end
      OP_INV:    begin result = ~rd;            reg_we = 1'b1; end
      OP_MVI:    begin result = imm_ext;        reg_we = 1'b1; end
      OP_CMPLT:  begin flag_we = 1'b1; flag_val = (rd < rs);       end
      OP_CMPEQ:  begin flag_we = 1'b1; flag_val = (rd == rs);      end
      OP_CMPEQI: begin flag_we = 1'b1; flag_val = (rd == imm_ext); end
      default:   ;
    endcase
  end

endmodule

// File: rtl/exe_ctrl.sv
// Execution unit controller: accepts one decoded instruction per id handshake,
// owns the register file and compare flag, runs ALU ops in one EXEC cycle and
// sequences ld/str over the req/ack memory port; reports completion on
// registered wb/retire/illegal pulses.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : exe_ctrl_if.slave (decode, memory and status signals)
module exe_ctrl
  import exe_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned RAW = RAW_DEF,
  parameter int unsigned MAW = MAW_DEF
) (
  input logic       clock,
  input logic       reset_n,
  exe_ctrl_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** RAW;

  state_e         state, state_nx;
  op_e            op_in, op_q;
  logic [NUM_OPS-1:0] strobes;
  logic [MAW-1:0] imm_q;
  logic [RAW-1:0] src_q, dst_q;
  logic [DW-1:0]  regs [NUM_REGS];
  logic           flag_q;
  logic           ready;
  logic           in_mem, is_store;

  logic [DW-1:0]  alu_result;
  logic           alu_reg_we, alu_flag_we, alu_flag_val;

  logic           wb_valid_q, retire_q, illegal_q;
  logic [RAW-1:0] wb_reg_q;
  logic [DW-1:0]  wb_data_q;

  assign strobes = {bus.id_mvi_i, bus.id_inv_i, bus.id_shftl_i, bus.id_shftr_i,
                    bus.id_cmpeqi_i, bus.id_cmpeq_i, bus.id_cmplt_i, bus.id_addi_i,
                    bus.id_add_i, bus.id_str_i, bus.id_and_i, bus.id_ld_i};
  assign op_in   = encode_op(strobes);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.id_valid_i) state_nx = (op_in == OP_LD || op_in == OP_STR) ? MEM : EXEC;
      end
      EXEC:    state_nx = IDLE;
      MEM:     if (bus.mem_ack_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  exe_alu #(.DW(DW), .MAW(MAW)) u_alu (
    .op       (op_q),
    .rd       (regs[dst_q]),
    .rs       (regs[src_q]),
    .imm      (imm_q),
    .result   (alu_result),
    .reg_we   (alu_reg_we),
    .flag_we  (alu_flag_we),
    .flag_val (alu_flag_val)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_ILL;
      imm_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      flag_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      retire_q   <= 1'b0;
      illegal_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      retire_q   <= 1'b0;
      illegal_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.id_valid_i) begin
            op_q  <= op_in;
            imm_q <= bus.imm_addr_const_i;
            src_q <= bus.src_reg_i;
            dst_q <= bus.dst_reg_i;
          end
        end
        EXEC: begin
          if (op_q == OP_ILL) illegal_q <= 1'b1;
          else                retire_q  <= 1'b1;
          if (alu_reg_we) begin
            regs[dst_q] <= alu_result;
            wb_valid_q  <= 1'b1;
            wb_reg_q    <= dst_q;
            wb_data_q   <= alu_result;
          end
          if (alu_flag_we) flag_q <= alu_flag_val;
        end
        MEM: begin
          if (bus.mem_ack_i) begin
            retire_q <= 1'b1;
            if (op_q == OP_LD) begin
              regs[dst_q] <= bus.mem_rdata_i;
              wb_valid_q  <= 1'b1;
              wb_reg_q    <= dst_q;
              wb_data_q   <= bus.mem_rdata_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory outputs decode straight from the state register so a reset drops
  // mem_req_o immediately; fields stay stable because nothing they depend on
  // changes while in MEM.
  assign in_mem   = (state == MEM);
  assign is_store = (op_q == OP_STR);

  assign bus.id_ready_o  = ready;
  assign bus.mem_req_o   = in_mem;
  assign bus.mem_we_o    = in_mem && is_store;
  assign bus.mem_addr_o  = in_mem ? imm_q : '0;
  assign bus.mem_wdata_o = (in_mem && is_store) ? regs[src_q] : '0;
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_reg_o    = wb_reg_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.cmp_flag_o  = flag_q;
  assign bus.retire_o    = retire_q;
  assign bus.illegal_o   = illegal_q;

endmodule
